// File: rtl/imem_dmem_apb_arbiter.sv
// rtl/imem_dmem_apb_arbiter.sv - round-robin 2:1 APB arbiter sharing one memory slave between IMEM and DMEM
module imem_dmem_apb_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DAT_W      = 32,
  parameter bit FIRST_PRIO = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s0_psel,
  input  logic                s0_penable,
  input  logic                s0_pwrite,
  input  logic [ADDR_W-1:0]   s0_paddr,
  input  logic [DAT_W-1:0]    s0_pwdata,
  input  logic [DAT_W/8-1:0]  s0_pstrb,
  output logic [DAT_W-1:0]    s0_prdata,
  output logic                s0_pready,
  output logic                s0_pslverr,
  input  logic                s1_psel,
  input  logic                s1_penable,
  input  logic                s1_pwrite,
  input  logic [ADDR_W-1:0]   s1_paddr,
  input  logic [DAT_W-1:0]    s1_pwdata,
  input  logic [DAT_W/8-1:0]  s1_pstrb,
  output logic [DAT_W-1:0]    s1_prdata,
  output logic                s1_pready,
  output logic                s1_pslverr,
  output logic                m_psel,
  output logic                m_penable,
  output logic                m_pwrite,
  output logic [ADDR_W-1:0]   m_paddr,
  output logic [DAT_W-1:0]    m_pwdata,
  output logic [DAT_W/8-1:0]  m_pstrb,
  input  logic [DAT_W-1:0]    m_prdata,
  input  logic                m_pready,
  input  logic                m_pslverr,
  output logic                grant_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;
  logic   win;
  logic   done;
  logic   s0_done;
  logic   s1_done;

  // A tie goes to whoever did not own the previous transfer.
  always_comb begin
    win = 1'b0;
    if (s0_psel && s1_psel) begin
      win = ~grant_o;
    end else if (s1_psel) begin
      win = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_o   <= ~FIRST_PRIO;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      m_pstrb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s0_psel || s1_psel) begin
            grant_o  <= win;
            m_pwrite <= win ? s1_pwrite : s0_pwrite;
            m_paddr  <= win ? s1_paddr  : s0_paddr;
            m_pwdata <= win ? s1_pwdata : s0_pwdata;
            m_pstrb  <= win ? s1_pstrb  : s0_pstrb;
            m_psel   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          m_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (m_pready) begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          m_psel    <= 1'b0;
          m_penable <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // A requester that has dropped out of its access phase never gets the response.
  assign done    = (state == ACCESS) && m_pready;
  assign s0_done = done && !grant_o && s0_psel && s0_penable;
  assign s1_done = done &&  grant_o && s1_psel && s1_penable;

  assign s0_pready  = s0_done;
  assign s0_prdata  = s0_done ? m_prdata : '0;
  assign s0_pslverr = s0_done && m_pslverr;
  assign s1_pready  = s1_done;
  assign s1_prdata  = s1_done ? m_prdata : '0;
  assign s1_pslverr = s1_done && m_pslverr;

endmodule

// File: tb/tb_imem_dmem_apb_arbiter.sv
// tb/tb_imem_dmem_apb_arbiter.sv - self-checking bench for imem_dmem_apb_arbiter
module tb_imem_dmem_apb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]          psel, penable, pwrite, pready, pslverr;
  logic [1:0][AW-1:0]  paddr;
  logic [1:0][DW-1:0]  pwdata, prdata;
  logic [1:0][SW-1:0]  pstrb;
  logic                m_psel, m_penable, m_pwrite, m_pready, m_pslverr, grant_o;
  logic [AW-1:0]       m_paddr;
  logic [DW-1:0]       m_pwdata, m_prdata;
  logic [SW-1:0]       m_pstrb;

  imem_dmem_apb_arbiter #(.ADDR_W(AW), .DAT_W(DW), .FIRST_PRIO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_psel(psel[0]), .s0_penable(penable[0]), .s0_pwrite(pwrite[0]), .s0_paddr(paddr[0]),
    .s0_pwdata(pwdata[0]), .s0_pstrb(pstrb[0]), .s0_prdata(prdata[0]), .s0_pready(pready[0]),
    .s0_pslverr(pslverr[0]),
    .s1_psel(psel[1]), .s1_penable(penable[1]), .s1_pwrite(pwrite[1]), .s1_paddr(paddr[1]),
    .s1_pwdata(pwdata[1]), .s1_pstrb(pstrb[1]), .s1_prdata(prdata[1]), .s1_pready(pready[1]),
    .s1_pslverr(pslverr[1]),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_prdata(m_prdata), .m_pready(m_pready),
    .m_pslverr(m_pslverr), .grant_o(grant_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          req;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] rdata;
    bit          err;
    bit          chg;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic idle_inputs();
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0;
    m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int r;
    int o;
    r = int'(v.req);
    o = 1 - r;
    @(posedge clk); #1;
    psel[r] = 1'b1; penable[r] = 1'b0; pwrite[r] = v.write;
    paddr[r] = v.addr; pwdata[r] = v.wdata; pstrb[r] = v.strb;
    m_pready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_c0_msel", n), 128'(m_psel), 128'(0));
    @(posedge clk); #1;
    penable[r] = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_setup", n), 128'({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb}),
          128'({1'b1, 1'b0, v.write, v.addr, v.wdata, v.strb}));
    check($sformatf("v%0d_setup_rdy", n), 128'(pready), 128'(0));
    for (int c = 0; c <= v.waits; c++) begin
      @(posedge clk); #1;
      if (v.chg) begin
        paddr[r]  = v.addr + 32'h40;
        pwdata[r] = ~v.wdata;
      end
      m_pready  = (c == v.waits);
      m_prdata  = m_pready ? v.rdata : $urandom;
      m_pslverr = m_pready ? v.err : 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_acc%0d_m", n, c), 128'({m_psel, m_penable, m_paddr, m_pwdata}),
            128'({1'b1, 1'b1, v.addr, v.wdata}));
      check($sformatf("v%0d_acc%0d_rdy", n, c), 128'(pready[r]), 128'(c + 2 == v.exp_lat));
      check($sformatf("v%0d_acc%0d_resp", n, c), 128'({prdata[r], pslverr[r]}),
            (c + 2 == v.exp_lat) ? 128'({v.exp_rdata, v.exp_err}) : 128'(0));
      check($sformatf("v%0d_acc%0d_other", n, c), 128'({pready[o], pslverr[o], prdata[o]}), 128'(0));
    end
    @(posedge clk); #1;
    psel[r] = 1'b0; penable[r] = 1'b0;
    m_pready = 1'b0; m_pslverr = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_end", n), 128'({m_psel, m_penable, grant_o}), 128'({1'b0, 1'b0, v.req}));
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (st[b]) res[b*8 +: 8] = wd[b*8 +: 8];
    return res;
  endfunction

  logic [31:0] ref_mem[16];
  logic [31:0] slv_mem[16];
  int          rph[2];
  bit          rdone[2];
  logic [3:0]  ridx[2];
  int          ow[2];
  int          wait_left;
  bit          inj_err;

  task automatic start_req(input int i);
    rph[i] = 1;
    psel[i] = 1'b1; penable[i] = 1'b0;
    pwrite[i] = 1'($urandom_range(0, 1));
    ridx[i] = 4'($urandom_range(0, 15));
    paddr[i] = {26'h0, ridx[i], 2'b00};
    pwdata[i] = $urandom;
    pstrb[i] = 4'($urandom);
    ow[i] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[6];
    int ncomp, last, first_win;
    bit [1:0] fin;

    vecs[0] = '{req:0, write:0, addr:32'h40,  wdata:32'h0,        strb:4'h0, waits:0, rdata:32'hDEADBEEF,
                err:0, chg:0, exp_rdata:32'hDEADBEEF, exp_err:0, exp_lat:2};
    vecs[1] = '{req:1, write:1, addr:32'h100, wdata:32'h12345678, strb:4'hF, waits:0, rdata:32'h0,
                err:0, chg:0, exp_rdata:32'h0, exp_err:0, exp_lat:2};
    vecs[2] = '{req:1, write:1, addr:32'h200, wdata:32'hA5A5A5A5, strb:4'hF, waits:3, rdata:32'h0BAD0BAD,
                err:1, chg:0, exp_rdata:32'h0BAD0BAD, exp_err:1, exp_lat:5};
    vecs[3] = '{req:0, write:0, addr:32'h40,  wdata:32'h0,        strb:4'h0, waits:1, rdata:32'hCAFEF00D,
                err:0, chg:1, exp_rdata:32'hCAFEF00D, exp_err:0, exp_lat:3};
    vecs[4] = '{req:0, write:1, addr:32'h84,  wdata:32'h11223344, strb:4'h3, waits:2, rdata:32'h77,
                err:0, chg:0, exp_rdata:32'h77, exp_err:0, exp_lat:4};
    vecs[5] = '{req:1, write:0, addr:32'hFFC, wdata:32'h0,        strb:4'h0, waits:0, rdata:32'h600DD00D,
                err:1, chg:1, exp_rdata:32'h600DD00D, exp_err:1, exp_lat:2};

    do_reset();
    @(negedge clk);
    check("reset_m", 128'({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb}), 128'(0));
    check("reset_s", 128'({pready, pslverr, prdata}), 128'(0));
    check("reset_grant", 128'(grant_o), 128'(0));

    for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

    // Ties from reset: FIRST_PRIO first, then strict alternation.
    do_reset();
    m_pready = 1'b1; m_prdata = 32'h5555AAAA;
    psel = 2'b11; penable = 2'b00; pwrite = 2'b10;
    paddr[0] = 32'h40; paddr[1] = 32'h100; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
    ncomp = 0; last = 0;
    for (int k = 0; k < 40 && ncomp < 6; k++) begin
      @(negedge clk);
      fin = pready;
      for (int i = 0; i < 2; i++) begin
        if (pready[i]) begin
          order[ncomp] = i;
          check($sformatf("tie%0d_grant", ncomp), 128'(grant_o), 128'(i));
          check($sformatf("tie%0d_cycle", ncomp), 128'(k - last), 128'((ncomp == 0) ? 2 : 3));
          if (ncomp == 0)
            check("tie0_req", 128'({m_pwrite, m_paddr, m_pwdata, m_pstrb}),
                  128'({1'b1, 32'h100, 32'h12345678, 4'hF}));
          last = k;
          ncomp++;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (fin[i]) penable[i] = 1'b0;
        else if (psel[i]) penable[i] = 1'b1;
      end
    end
    check("tie_count", 128'(ncomp), 128'(6));
    for (int j = 0; j < ncomp; j++) check($sformatf("tie%0d_order", j), 128'(order[j]), 128'((j % 2 == 0) ? 1 : 0));

    // Requester abandons its access phase: memory completes, no pready returned.
    do_reset();
    psel[0] = 1'b1; paddr[0] = 32'h44;
    @(posedge clk); #1 penable[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0; m_pready = 1'b1; m_pslverr = 1'b1; m_prdata = 32'h12;
    @(negedge clk);
    check("drop_access", 128'({m_psel, m_penable, pready, pslverr, prdata}), 128'({2'b11, 68'h0}));
    @(posedge clk); #1 m_pready = 1'b0; m_pslverr = 1'b0;
    @(negedge clk);
    check("drop_idle", 128'(m_psel), 128'(0));

    // Async reset while s1 owns a stalled transfer; next tie must go to FIRST_PRIO.
    do_reset();
    psel[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h300; pwdata[1] = 32'h99;
    @(posedge clk); #1 penable[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pre", 128'({m_psel, m_penable, grant_o}), 128'(3'b111));
    #2 rst_n = 1'b0; m_pready = 1'b1;
    #1;
    check("rst_async_m", 128'({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}), 128'(0));
    check("rst_async_s", 128'({pready, pslverr, grant_o}), 128'(0));
    psel = '0; penable = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    psel = 2'b11;
    first_win = -1;
    for (int k = 0; k < 10 && first_win < 0; k++) begin
      @(negedge clk);
      if (pready[0]) first_win = 0;
      else if (pready[1]) first_win = 1;
      @(posedge clk); #1 penable = psel;
    end
    check("rst_tie_winner", 128'(first_win), 128'(1));

    // Randomised traffic against a memory/arbitration model.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = 32'h01010101 * a;
      slv_mem[a] = 32'h01010101 * a;
    end
    rph = '{0, 0}; rdone = '{0, 0}; ow = '{0, 0}; wait_left = 0; inj_err = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        case (rph[i])
          0: if ($urandom_range(0, 2) == 0) start_req(i);
          1: begin rph[i] = 2; penable[i] = 1'b1; end
          default: if (rdone[i]) begin
            rdone[i] = 1'b0;
            if ($urandom_range(0, 1) == 1) start_req(i);
            else begin rph[i] = 0; psel[i] = 1'b0; penable[i] = 1'b0; end
          end
        endcase
      end
      @(negedge clk);
      if (m_psel && !m_penable) begin
        wait_left = $urandom_range(0, 3);
        m_pready = 1'($urandom); m_pslverr = 1'($urandom); m_prdata = $urandom;
      end else if (m_psel && m_penable && wait_left == 0) begin
        inj_err = ($urandom_range(0, 3) == 0);
        m_pready = 1'b1; m_pslverr = inj_err; m_prdata = slv_mem[m_paddr[5:2]];
        if (m_pwrite) slv_mem[m_paddr[5:2]] = merge(slv_mem[m_paddr[5:2]], m_pwdata, m_pstrb);
      end else if (m_psel && m_penable) begin
        wait_left--;
        m_pready = 1'b0; m_pslverr = 1'($urandom); m_prdata = $urandom;
      end else begin
        m_pready = 1'($urandom); m_pslverr = 1'($urandom); m_prdata = $urandom;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
        if (pready[i]) begin
          check("rnd_phase", 128'(rph[i]), 128'(2));
          check("rnd_owner", 128'(grant_o), 128'(i));
          check("rnd_req", 128'({m_pwrite, m_paddr, m_pwdata, m_pstrb}),
                128'({pwrite[i], paddr[i], pwdata[i], pstrb[i]}));
          check("rnd_rdata", 128'(prdata[i]), 128'(ref_mem[ridx[i]]));
          check("rnd_err", 128'(pslverr[i]), 128'(inj_err));
          check("rnd_fair", 128'(ow[i] <= 1), 128'(1));
          if (pwrite[i]) ref_mem[ridx[i]] = merge(ref_mem[ridx[i]], pwdata[i], pstrb[i]);
          rdone[i] = 1'b1;
          if (rph[1-i] != 0) ow[1-i]++;
        end else begin
          check("rnd_gate", 128'({prdata[i], pslverr[i]}), 128'(0));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_dmem_apb_arbiter.md
Name: imem_dmem_apb_arbiter

Overview:
Two-to-one APB arbiter that shares a single unified memory APB slave between the fetch unit's IMEM port (requester 0) and the load/store unit's DMEM port (requester 1).
- Each requester sees an APB slave. The arbiter stalls the losing requester with PREADY low.
- The arbiter replays the winning transfer on its master port and returns the response.
- It sits between the core's two APB masters and the memory subsystem. Grant is round-robin, with a configurable preference on the first simultaneous request after reset.

Parameters:
ADDR_W, 32, address width on all ports
DAT_W, 32, data width on all ports
FIRST_PRIO, 1, requester index granted on the first simultaneous request after reset

Ports:
clk  in  1  rising-edge reference clock
rst_n  in  1  asynchronous active-low reset
s0_psel/s1_psel  in  1  requester select (s0=IMEM, s1=DMEM)
s0_penable/s1_penable  in  1  requester access phase
s0_pwrite/s1_pwrite  in  1  requester direction
s0_paddr/s1_paddr  in  ADDR_W  requester address
s0_pwdata/s1_pwdata  in  DAT_W  requester write data
s0_pstrb/s1_pstrb  in  DAT_W/8  requester byte strobes
s0_prdata/s1_prdata  out  DAT_W  read data to requester
s0_pready/s1_pready  out  1  transfer complete to requester
s0_pslverr/s1_pslverr  out  1  error to requester
m_psel  out  1  memory select
m_penable  out  1  memory access phase
m_pwrite  out  1  memory direction
m_paddr  out  ADDR_W  memory address
m_pwdata  out  DAT_W  memory write data
m_pstrb  out  DAT_W/8  memory strobes
m_prdata  in  DAT_W  memory read data
m_pready  in  1  memory ready
m_pslverr  in  1  memory error
grant_o  out  1  owner of current or last transfer (0/1), for debug/perf counters

Behaviour:
Reset:
- State goes to IDLE. All m_* outputs, sN_pready, sN_pslverr and sN_prdata are 0.
- grant_o = ~FIRST_PRIO, so FIRST_PRIO wins the first tie.

FSM states: IDLE, SETUP, ACCESS.

IDLE:
- Arbitrates among requesters with sN_psel=1.
- A single requester wins.
- If both request, the winner is ~grant_o (round-robin).
- On a win: grant_o <= winner; pwrite/paddr/pwdata/pstrb are latched from the winner into internal registers; next state is SETUP.
- With no request, the FSM stays in IDLE.

SETUP:
- Drives m_psel=1, m_penable=0 and the latched control/data.
- Always goes to ACCESS next cycle.

ACCESS:
- Drives m_psel=1 and m_penable=1, holding all latched fields.
- When m_pready=1:
  - s[grant]_pready=1, s[grant]_prdata=m_prdata, s[grant]_pslverr=m_pslverr, all combinationally in the same cycle.
  - Next state is IDLE.
- Otherwise the FSM stays in ACCESS (memory wait states pass through unbounded).

Response gating:
- The non-granted requester sees pready=0 and pslverr=0.
- prdata and pslverr are zeroed whenever the corresponding pready=0.

Latency:
- Requester SETUP in cycle 0 (IDLE samples psel). Memory SETUP in cycle 1, memory ACCESS in cycle 2.
- With zero-wait memory, requester pready=1 in cycle 2. That is one extra cycle versus direct connection.
- Back-to-back: after completion one IDLE cycle always occurs, so the maximum throughput is one transfer per 3 cycles.

Fairness: a pending requester waits for at most one transfer of the other requester.

Boundary cases:
- Requester deasserts psel before pready (protocol violation): the memory transfer still completes and the response is discarded. No pready is returned to a deselected requester.
- Requester changes paddr/pwdata mid-transfer: ignored, because latched values are used.
- m_pslverr=1: forwarded unchanged to the owner. The FSM returns to IDLE normally, with no retry.
- Both requesters present in the same IDLE cycle as grant_o toggles: the decision uses the registered grant_o value.
- rst_n asserted mid-transfer: immediate return to IDLE with all outputs at reset values. The in-flight memory transfer is abandoned.

Test Plan:
1. s0 only reads 0x0000_0040, memory returns 0xDEAD_BEEF with 0 waits -> m_psel rises in cycle 1, m_penable in cycle 2. s0_pready=1 with s0_prdata=0xDEAD_BEEF in cycle 2; s1_pready stays 0.
2. s0 and s1 both request from reset with FIRST_PRIO=1 -> s1 (write 0x100, 0x1234_5678, pstrb=0xF) is served first. Then s0 is served, with one IDLE cycle between; grant_o reads 1 then 0.
3. Continuous dual requests over 6 transfers -> grant order 1,0,1,0,1,0. No requester is served twice consecutively.
4. s1 write with memory inserting 3 wait states and m_pslverr=1 on completion -> s1_pready high only in the completion cycle with s1_pslverr=1. s0_pslverr stays 0.
5. s0 changes paddr from 0x40 to 0x80 during ACCESS -> m_paddr stays 0x40 for the whole transfer.
6. rst_n pulsed low during ACCESS with memory waiting -> all m_* and sN_pready go to 0 asynchronously. After release, the next tie is granted to FIRST_PRIO.
